// File: rtl/my_fsm_pkg.sv
// Shared types and constants for the "110" sequence detector.
package my_fsm_pkg;

  // 2-bit state encoding; DET is the only state that drives the flag
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    DET  = 2'd3
  } state_t;

  // Detected pattern, oldest bit in the MSB
  localparam logic [2:0] PATTERN = 3'b110;

endpackage

// File: rtl/my_fsm.sv
// Moore detector for serial pattern "110" with overlap.
// The flag is a pure decode of the state register, so there is no path from in to out.
module my_fsm
  import my_fsm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t r_state;
  state_t w_next;

  // State register, cleared asynchronously to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a run of 1s keeps S11 armed, and DET hands a new 1 to S1 for overlap
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = in ? S1  : IDLE;
      S1:      w_next = in ? S11 : IDLE;
      S11:     w_next = in ? S11 : DET;
      DET:     w_next = in ? S1  : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign out = (r_state == DET);

endmodule

// File: tb/tb_my_fsm.sv
// Self-checking bench for my_fsm: a bit-history model pushes the expected flag
// into a scoreboard as each bit is driven; it is popped after the sampling edge.
module tb_my_fsm;
  import my_fsm_pkg::*;

  logic clock;
  logic reset;
  logic in;
  logic out;

  int n_chk  = 0;
  int n_fail = 0;

  logic       sb[$];
  logic [2:0] hist;
  int         cnt;

  my_fsm dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive one bit, model it, check after the next edge
  task automatic step(input string tag, input logic b);
    logic e;
    in   = b;
    hist = {hist[1:0], b};
    cnt++;
    sb.push_back((cnt >= 3) && (hist == PATTERN));
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk(tag, out, e);
    end
  endtask

  // Drive the low n bits of v, most significant first
  task automatic run(input string tag, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, v[i]);
  endtask

  // Mid-cycle reset pulse; flag must drop before any clock edge
  task automatic rst_pulse(input string tag);
    #2 reset = 1'b1;
    #1 chk(tag, out, 1'b0);
    hist = 3'b000;
    cnt  = 0;
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [15:0] rv;
    reset = 1'b0;
    in    = 1'b0;
    hist  = 3'b000;
    cnt   = 0;
    #1 reset = 1'b1;
    #1 chk("rst_async_init", out, 1'b0);
    @(posedge clock);
    #1 chk("rst_held", out, 1'b0);
    reset = 1'b0;

    step("rst_first", 1'b0);
    run("basic_110", 16'b110, 3);
    run("exit", 16'b10, 2);
    run("long_prefix", 16'b11110, 5);
    run("overlap", 16'b110110, 6);
    run("nonmatch", 16'b1010, 4);

    // reset while in DET: flag must fall immediately
    run("to_det", 16'b110, 3);
    rst_pulse("async_rst_det");

    // reset while in S11: a following 0 must not complete the pattern
    run("to_s11", 16'b11, 2);
    rst_pulse("async_rst_s11");
    step("post_rst", 1'b0);
    run("post_rst_tail", 16'b0110, 4);

    // random stream against the same model
    for (int k = 0; k < 4; k++) begin
      rv = 16'($urandom);
      run("random", rv, 16);
    end

    if (sb.size() != 0) chk("sb_drain", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
